hyper_cord_sinh_cosh: RTL and testbench
=======================================

HYPER_CORD_SINH_COSH -- requirements
Module: hyper_cord_sinh_cosh

Interface
REQ-001 SHALL have parameters: IDWIDTH, 8, input width (hyperCord_pkg: 1 sign + 5 int + 2 frac, two's complement).
REQ-002 SHALL have parameter: ODWIDTH, 16, output width (signed, 14 frac bits, Q1.14).
REQ-003 SHALL have parameter: NSTEP, 16, micro-rotations (shift sequence 1,2,3,4,4,5..13,13,14).
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 Ports SHALL be: iClk  in  1  clock, rising edge.
REQ-006 iRst  in  1  asynchronous active-high reset.
REQ-007 iData  in  IDWIDTH  angle, two's complement.
REQ-008 iValid  in  1  iData valid.
REQ-009 oReady  out  1  block accepts iData.
REQ-010 oCosh  out  ODWIDTH  cosh(angle), signed Q1.14.
REQ-011 oSinh  out  ODWIDTH  sinh(angle), signed Q1.14.
REQ-012 oOvf  out  1  input magnitude clipped, qualified by oValid.
REQ-013 oValid  out  1  results valid.
REQ-014 iReady  in  1  downstream accepts results.

Function
REQ-015 FSM states SHALL be IDLE, ITER, SIGN, DONE; oReady=1 only in IDLE.
REQ-016 Accept edge T (IDLE, iValid&oReady): capture sign=iData[MSB], magnitude=|iData| (two's complement), go ITER, step counter=0.
REQ-017 Magnitude above 1.0 (4 LSB), and iData=0x80, SHALL saturate to 1.0 with oOvf latched 1; else oOvf latched 0.
REQ-018 Init at T: z=magnitude<<12 (Q3.14, 18-bit signed), x=19784 (1/Kh in Q3.14), y=0.
REQ-019 Edges T+1..T+16: one micro-rotation each, shift i per REQ-003; d=+1 if z>=0 else -1.
REQ-020 Micro-rotation: x'=x+d*(y>>>i), y'=y+d*(x>>>i), z'=z-d*A[i]; arithmetic shifts, 18-bit internal, no saturation.
REQ-021 A[i] SHALL be round-to-nearest of atanh(2^-i)*2^14, constant table indexed by i.
REQ-022 After 16th step go SIGN; edge T+17: oCosh=x[15:0], oSinh=y[15:0] if sign=0 else two's-complement negate of y[15:0]; go DONE.
REQ-023 oValid SHALL be 1 exactly while in DONE (first high after edge T+17); outputs stable while oValid=1.
REQ-024 DONE with iReady=1 at an edge: oValid drops, return IDLE; no same-edge acceptance (min period 19 cycles).
REQ-025 DONE with iReady=0: hold indefinitely, outputs unchanged.
REQ-026 iData/iValid changes outside IDLE SHALL be ignored.
REQ-027 Accuracy: |oCosh-ideal|, |oSinh-ideal| <= 8 LSB over all legal inputs.

Reset
REQ-028 iRst=1 SHALL immediately force IDLE, oValid=0, oReady=0 while asserted, oCosh=oSinh=0, oOvf=0, internal x/y/z/counter=0.
REQ-029 oReady SHALL rise on the first clock edge after iRst deasserts.
REQ-030 Reset during ITER/SIGN/DONE SHALL discard the in-flight operation; no oValid for it.

Verification
REQ-031 iData=0x00 -> oCosh=16384±8, oSinh=0±8, oOvf=0, oValid at T+17.
REQ-032 iData=0x04 (1.0) -> oCosh=25282±8, oSinh=19254±8, oOvf=0.
REQ-033 iData=0xFE (-0.5) -> oCosh=18475±8, oSinh=-8538±8, oOvf=0.
REQ-034 iData=0x80 and 0x7F -> oOvf=1, oCosh=25282±8, oSinh=-19254±8 resp. +19254±8.
REQ-035 iReady=0 for 10 cycles in DONE -> oValid and outputs held; iValid pulses ignored; one result on release.
REQ-036 iRst pulse at T+8 -> all outputs 0 immediately, no oValid, oReady=1 the edge after release, next accept runs normally.

Source files
------------

// File: rtl/hyper_cord_sinh_cosh.sv
// Hyperbolic CORDIC (rotation mode) producing cosh/sinh of a Q5.2 angle as Q1.14.
// Angles with magnitude above 1.0 are clipped to 1.0 and flagged on oOvf.
module hyper_cord_sinh_cosh #(
    parameter int IDWIDTH = 8,
    parameter int ODWIDTH = 16,
    parameter int NSTEP   = 16
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic [IDWIDTH-1:0] iData,
    input  logic               iValid,
    output logic               oReady,
    output logic [ODWIDTH-1:0] oCosh,
    output logic [ODWIDTH-1:0] oSinh,
    output logic               oOvf,
    output logic               oValid,
    input  logic               iReady
);

    localparam int W       = 18;
    localparam int CW      = $clog2(NSTEP);
    localparam int FRAC_IN = 2;
    localparam int FRAC_Z  = 14;
    localparam logic signed [W-1:0] INV_KH = W'(19784);

    typedef enum logic [1:0] {IDLE, ITER, SIGN, DONE} state_t;

    // Shift sequence 1,2,3,4,4,5..13,13,14: repeats at 4 and 13 keep the series convergent.
    function automatic int shift_of(input int k);
        if (k <= 3)       return k + 1;
        else if (k <= 13) return k;
        else if (k == 14) return 13;
        else              return 14;
    endfunction

    function automatic logic signed [W-1:0] atanh_of(input int s);
        case (s)
            1:       return W'(9000);
            2:       return W'(4185);
            3:       return W'(2059);
            4:       return W'(1025);
            5:       return W'(512);
            6:       return W'(256);
            7:       return W'(128);
            8:       return W'(64);
            9:       return W'(32);
            10:      return W'(16);
            11:      return W'(8);
            12:      return W'(4);
            13:      return W'(2);
            14:      return W'(1);
            default: return '0;
        endcase
    endfunction

    state_t                 state;
    logic   [CW-1:0]        cnt;
    logic signed [W-1:0]    x, y, z;
    logic                   sgn;

    logic   [IDWIDTH-1:0]   mag, mag_sat;
    logic                   sat;
    logic signed [W-1:0]    z_init;
    logic signed [W-1:0]    xs, ys, ang;
    logic                   d_pos;
    int                     sh;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        mag     = iData[IDWIDTH-1] ? (~iData + 1'b1) : iData;
        sat     = mag > IDWIDTH'(1 << FRAC_IN);
        mag_sat = sat ? IDWIDTH'(1 << FRAC_IN) : mag;
        z_init  = W'(mag_sat) << (FRAC_Z - FRAC_IN);
        sh      = shift_of(int'(cnt));
        xs      = x >>> sh;
        ys      = y >>> sh;
        ang     = atanh_of(sh);
        d_pos   = ~z[W-1];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state  <= IDLE;
            cnt    <= '0;
            x      <= '0;
            y      <= '0;
            z      <= '0;
            sgn    <= 1'b0;
            oReady <= 1'b0;
            oValid <= 1'b0;
            oCosh  <= '0;
            oSinh  <= '0;
            oOvf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iValid && oReady) begin
                        sgn    <= iData[IDWIDTH-1];
                        oOvf   <= sat;
                        x      <= INV_KH;
                        y      <= '0;
                        z      <= z_init;
                        cnt    <= '0;
                        oReady <= 1'b0;
                        state  <= ITER;
                    end else begin
                        oReady <= 1'b1;
                    end
                end
                ITER: begin
                    x   <= d_pos ? x + ys  : x - ys;
                    y   <= d_pos ? y + xs  : y - xs;
                    z   <= d_pos ? z - ang : z + ang;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(NSTEP - 1)) state <= SIGN;
                end
                SIGN: begin
                    oCosh  <= x[ODWIDTH-1:0];
                    oSinh  <= sgn ? (ODWIDTH'(0) - y[ODWIDTH-1:0]) : y[ODWIDTH-1:0];
                    oValid <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    if (iReady) begin
                        oValid <= 1'b0;
                        oReady <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hyper_cord_sinh_cosh.sv
// Self-checking bench for hyper_cord_sinh_cosh: directed and random angles against
// a real-valued cosh/sinh model, plus latency, back-pressure and mid-operation reset.
module tb_hyper_cord_sinh_cosh;

    logic        iClk = 1'b0;
    logic        iRst;
    logic [7:0]  iData;
    logic        iValid;
    logic        oReady;
    logic [15:0] oCosh, oSinh;
    logic        oOvf, oValid;
    logic        iReady;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 iClk = ~iClk;

    hyper_cord_sinh_cosh #(.IDWIDTH(8), .ODWIDTH(16), .NSTEP(16)) dut (
        .iClk(iClk), .iRst(iRst), .iData(iData), .iValid(iValid), .oReady(oReady),
        .oCosh(oCosh), .oSinh(oSinh), .oOvf(oOvf), .oValid(oValid), .iReady(iReady)
    );

    task automatic check(input string tag, input int obs, input int exp, input int tol);
        int diff;
        n_checks++;
        diff = obs - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // Reference: angle in units of 1/4, clipped to +-1.0, ideal cosh/sinh scaled by 2^14.
    task automatic model(input logic [7:0] d, output int ec, output int es, output int eo);
        int  v;
        real a;
        v  = int'($signed(d));
        eo = (v > 4 || v < -4) ? 1 : 0;
        if (eo != 0) a = (v < 0) ? -1.0 : 1.0;
        else         a = real'(v) / 4.0;
        ec = int'($cosh(a) * 16384.0);
        es = int'($sinh(a) * 16384.0);
    endtask

    task automatic wait_ready(input string tag);
        int t = 0;
        @(negedge iClk);
        while (!oReady && t < 50) begin
            @(negedge iClk);
            t++;
        end
        if (!oReady) check({tag, "_ready_timeout"}, 0, 1, 0);
    endtask

    task automatic run_op(input logic [7:0] d, input int hold, input string tag);
        int ec, es, eo, lat;
        model(d, ec, es, eo);
        wait_ready(tag);
        iData  = d;
        iValid = 1'b1;
        @(posedge iClk);
        #1;
        iValid = 1'b0;
        iData  = 8'($urandom);
        check({tag, "_busy_ready"}, int'(oReady), 0, 0);
        lat = 0;
        while (!oValid && lat < 40) begin
            @(posedge iClk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 17, 0);
        check({tag, "_cosh"}, int'($signed(oCosh)), ec, 8);
        check({tag, "_sinh"}, int'($signed(oSinh)), es, 8);
        check({tag, "_ovf"}, int'(oOvf), eo, 0);
        if (hold > 0) begin
            iReady = 1'b0;
            for (int k = 0; k < hold; k++) begin
                iValid = 1'($urandom_range(0, 1));
                iData  = 8'($urandom);
                @(posedge iClk);
                #1;
                check({tag, "_hold_valid"}, int'(oValid), 1, 0);
                check({tag, "_hold_cosh"}, int'($signed(oCosh)), ec, 8);
                check({tag, "_hold_sinh"}, int'($signed(oSinh)), es, 8);
            end
            iValid = 1'b0;
            iReady = 1'b1;
        end
        @(posedge iClk);
        #1;
        check({tag, "_release_valid"}, int'(oValid), 0, 0);
        check({tag, "_release_ready"}, int'(oReady), 1, 0);
    endtask

    task automatic quiet_window(input int cycles, input string tag);
        int seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge iClk);
            #1;
            if (oValid) seen++;
        end
        check({tag, "_no_valid"}, seen, 0, 0);
    endtask

    initial begin
        logic [7:0] directed [8] = '{8'h00, 8'h04, 8'hFE, 8'h80, 8'h7F, 8'hFC, 8'h01, 8'h05};

        iRst   = 1'b1;
        iData  = '0;
        iValid = 1'b0;
        iReady = 1'b1;
        repeat (3) @(posedge iClk);
        #1;
        check("rst_cosh", int'(oCosh), 0, 0);
        check("rst_sinh", int'(oSinh), 0, 0);
        check("rst_ovf", int'(oOvf), 0, 0);
        check("rst_valid", int'(oValid), 0, 0);
        check("rst_ready", int'(oReady), 0, 0);
        @(negedge iClk);
        iRst = 1'b0;
        @(posedge iClk);
        #1;
        check("rst_release_ready", int'(oReady), 1, 0);

        foreach (directed[i]) run_op(directed[i], 0, $sformatf("dir%0h", directed[i]));

        // Back-pressure: ten stalled cycles with ignored iValid pulses, then exactly one result.
        run_op(8'h04, 10, "hold");
        quiet_window(25, "hold_after");

        // Reset eight edges into an operation discards it.
        wait_ready("rstmid");
        iData  = 8'h04;
        iValid = 1'b1;
        @(posedge iClk);
        #1;
        iValid = 1'b0;
        repeat (7) @(posedge iClk);
        #2;
        iRst = 1'b1;
        #1;
        check("rstmid_cosh", int'(oCosh), 0, 0);
        check("rstmid_sinh", int'(oSinh), 0, 0);
        check("rstmid_ovf", int'(oOvf), 0, 0);
        check("rstmid_valid", int'(oValid), 0, 0);
        @(negedge iClk);
        check("rstmid_ready", int'(oReady), 0, 0);
        @(negedge iClk);
        iRst = 1'b0;
        @(posedge iClk);
        #1;
        check("rstmid_release_ready", int'(oReady), 1, 0);
        quiet_window(25, "rstmid");
        run_op(8'hFE, 0, "post_rst");

        for (int n = 0; n < 60; n++) begin
            run_op(8'($urandom), int'($urandom_range(0, 3)), $sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
